stream_fork_buffer: RTL

- Registered one-to-N eager fork for the sparse-stream fabric.
- Accepts one valid/ready token upstream and broadcasts it to every enabled output branch.
- Tracks per-branch delivery and retires the token only after every enabled branch has taken it.
- Sits directly downstream of the fanout ready-combine logic and replaces it on paths that need a registered boundary with branch-independent handshakes.

---
 rtl/stream_fork_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/stream_fork_buffer.sv
// stream_fork_buffer: registered one-to-N eager fork.
// Buffers one upstream token, broadcasts it to every enabled branch and
// retires it once each enabled branch has completed its own handshake.
module stream_fork_buffer #(
  parameter int NUM_OUT    = 6,
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    branch_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  retired_cnt
);

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [NUM_OUT-1:0]    sent;
  logic [NUM_OUT-1:0]    take;
  logic [NUM_OUT-1:0]    done;
  logic                  all_done;
  logic                  retire;
  logic                  accept;

  // Per-branch handshake view and the combined "everyone has it" condition.
  always_comb begin
    out_valid = {NUM_OUT{clk_en & buf_valid}} & branch_en & ~sent;
    take      = out_valid & out_ready;
    done      = ~branch_en | sent | take;
    all_done  = &done;
    retire    = buf_valid & all_done & clk_en;
    in_ready  = clk_en & ~flush & (~buf_valid | all_done);
    accept    = in_valid & in_ready;
  end

  assign out_data = buf_data;
  assign busy     = buf_valid;

  // Token buffer and delivery mask: load on accept, drop on retire,
  // otherwise remember which branches have already taken the token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      sent      <= '0;
    end else if (clk_en) begin
      if (flush) begin
        buf_valid <= 1'b0;
        sent      <= '0;
      end else if (accept) begin
        buf_valid <= 1'b1;
        buf_data  <= in_data;
        sent      <= '0;
      end else if (retire) begin
        buf_valid <= 1'b0;
        sent      <= '0;
      end else if (buf_valid) begin
        sent <= sent | take;
      end
    end
  end

  // Retired-token counter, wraps naturally and is cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (clk_en) begin
      if (flush) begin
        retired_cnt <= '0;
      end else if (retire) begin
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
